// File: rtl/param_register_file.sv
// Parametrised GPR file: hardwired-zero entry, write-to-read bypass, debug read
// port and a one-entry-per-cycle clear sweep under a req/busy/done handshake.

module prf_read_port #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                       byp_en,
    input  logic [AW-1:0]              addr,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    input  logic [NREGS-1:0][XLEN-1:0] regs_q,
    output logic [XLEN-1:0]            data
);
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic in_range;
    logic is_zero;

    assign in_range = {1'b0, addr} < NREGS_W;
    assign is_zero  = (ZERO_REG != 0) && (addr == '0);

    // wr_en already folds in busy, range and zero-register qualification
    always_comb begin
        data = '0;
        if (in_range && !is_zero) begin
            if (byp_en && wr_en && (wr_addr == addr))
                data = wr_data;
            else
                data = regs_q[addr];
        end
    end
endmodule

module param_register_file #(
    parameter int XLEN     = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] rs1,
    input  logic [$clog2(NREGS)-1:0] rs2,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic                     RegWrite,
    input  logic [XLEN-1:0]          Write_Data,
    output logic [XLEN-1:0]          Read_Data_1,
    output logic [XLEN-1:0]          Read_Data_2,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [XLEN-1:0]          dbg_data,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic                     clear_done
);
    localparam int          AW      = $clog2(NREGS);
    localparam int          NPORTS  = 3;
    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);
    localparam logic [AW:0] LAST    = (AW+1)'(NREGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [AW:0]                idx_q;
    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic                       wr_ok;

    logic [NPORTS-1:0][AW-1:0]   port_addr;
    logic [NPORTS-1:0][XLEN-1:0] port_data;
    logic [NPORTS-1:0]           port_byp;

    assign clear_busy = (state_q == S_CLEAR);
    assign clear_done = (state_q == S_DONE);

    assign wr_ok = RegWrite && !clear_busy && ({1'b0, rd} < NREGS_W) &&
                   !((ZERO_REG != 0) && (rd == '0));

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clear_req) state_d = S_CLEAR;
            S_CLEAR: if (idx_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // idx is AW+1 wide so the last-entry compare works when NREGS == 2**AW
    always_ff @(posedge clock) begin
        if (reset)
            idx_q <= '0;
        else if (state_q == S_IDLE && clear_req)
            idx_q <= '0;
        else if (state_q == S_CLEAR)
            idx_q <= idx_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            if (wr_ok)
                regs_q[rd] <= Write_Data;
            if (state_q == S_CLEAR)
                regs_q[idx_q[AW-1:0]] <= '0;
        end
    end

    // lanes: 0 = rs1, 1 = rs2, 2 = debug (never bypassed)
    assign port_addr = {dbg_addr, rs2, rs1};
    assign port_byp  = {1'b0, BYPASS != 0, BYPASS != 0};

    genvar g;
    generate
        for (g = 0; g < NPORTS; g++) begin : g_port
            prf_read_port #(
                .XLEN    (XLEN),
                .NREGS   (NREGS),
                .AW      (AW),
                .ZERO_REG(ZERO_REG)
            ) u_port (
                .byp_en (port_byp[g]),
                .addr   (port_addr[g]),
                .wr_en  (wr_ok),
                .wr_addr(rd),
                .wr_data(Write_Data),
                .regs_q (regs_q),
                .data   (port_data[g])
            );
        end
    endgenerate

    assign Read_Data_1 = port_data[0];
    assign Read_Data_2 = port_data[1];
    assign dbg_data    = port_data[2];
endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: three instances (32 regs bypass, 32 regs no bypass,
// 24 regs bypass) share one stimulus stream and are checked against an array model.

module tb_param_register_file;
    logic        clock;
    logic        reset;
    logic [4:0]  rs1, rs2, rd, dbg_addr;
    logic        RegWrite;
    logic [63:0] Write_Data;
    logic        clear_req;

    logic [63:0] r1 [3];
    logic [63:0] r2 [3];
    logic [63:0] dg [3];
    logic        bz [3];
    logic        dn [3];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [63:0] mem [3][32];
    bit          m_busy [3];
    int          m_pos [3];
    bit          m_done [3];
    int          NR [3]  = '{32, 32, 24};
    bit          BYP [3] = '{1'b1, 1'b0, 1'b1};

    param_register_file #(.XLEN(64), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut0 (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .RegWrite(RegWrite), .Write_Data(Write_Data),
        .Read_Data_1(r1[0]), .Read_Data_2(r2[0]), .dbg_addr(dbg_addr), .dbg_data(dg[0]),
        .clear_req(clear_req), .clear_busy(bz[0]), .clear_done(dn[0]));

    param_register_file #(.XLEN(64), .NREGS(32), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .RegWrite(RegWrite), .Write_Data(Write_Data),
        .Read_Data_1(r1[1]), .Read_Data_2(r2[1]), .dbg_addr(dbg_addr), .dbg_data(dg[1]),
        .clear_req(clear_req), .clear_busy(bz[1]), .clear_done(dn[1]));

    param_register_file #(.XLEN(64), .NREGS(24), .ZERO_REG(1), .BYPASS(1)) dut2 (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2), .rd(rd),
        .RegWrite(RegWrite), .Write_Data(Write_Data),
        .Read_Data_1(r1[2]), .Read_Data_2(r2[2]), .dbg_addr(dbg_addr), .dbg_data(dg[2]),
        .clear_req(clear_req), .clear_busy(bz[2]), .clear_done(dn[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] exp_rd(int c, int a, bit byp);
        if (a >= NR[c] || a == 0) return 64'h0;
        if (byp && BYP[c] && RegWrite && !m_busy[c] && int'(rd) == a) return Write_Data;
        return mem[c][a];
    endfunction

    task automatic model_step();
        for (int c = 0; c < 3; c++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) mem[c][i] = 64'h0;
                m_busy[c] = 0; m_pos[c] = 0; m_done[c] = 0;
            end else begin
                if (RegWrite && !m_busy[c] && int'(rd) < NR[c] && rd != 0)
                    mem[c][rd] = Write_Data;
                if (m_busy[c]) begin
                    mem[c][m_pos[c]] = 64'h0;
                    m_pos[c]++;
                    if (m_pos[c] == NR[c]) begin m_busy[c] = 0; m_done[c] = 1; end
                end else if (m_done[c]) m_done[c] = 0;
                else if (clear_req) begin m_busy[c] = 1; m_pos[c] = 0; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; RegWrite = 0; clear_req = 0; rd = 0; Write_Data = 0;
        rs1 = 0; rs2 = 0; dbg_addr = 0;
    endtask

    task automatic preload();
        for (int i = 1; i < 32; i++) begin
            RegWrite = 1; rd = 5'(i); Write_Data = 64'(i); tick();
        end
        RegWrite = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; tick(); reset = 0;
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a); rs2 = 5'(31 - a); #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (r1[c] !== 64'h0 || r2[c] !== 64'h0) begin
                    n_fail++;
                    $display("FAIL reset_read dut%0d addr %0d got %h/%h want 0", c, a, r1[c], r2[c]);
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bz[c] !== 1'b0 || dn[c] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d got busy=%b done=%b want 0/0", c, bz[c], dn[c]);
            end
        end
    endtask

    task automatic test_write_zero();
        idle_inputs();
        RegWrite = 1; rd = 5; Write_Data = 64'hDEADBEEF_CAFEF00D; tick();
        RegWrite = 0; rs1 = 5; #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (r1[c] !== 64'hDEADBEEF_CAFEF00D) begin
                n_fail++;
                $display("FAIL write_read dut%0d got %h want deadbeefcafef00d", c, r1[c]);
            end
        end
        RegWrite = 1; rd = 0; Write_Data = 64'h1234; tick();
        RegWrite = 0; rs2 = 0; dbg_addr = 0; #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (r2[c] !== 64'h0 || dg[c] !== 64'h0) begin
                n_fail++;
                $display("FAIL zero_reg dut%0d got rs2=%h dbg=%h want 0", c, r2[c], dg[c]);
            end
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        RegWrite = 1; rd = 7; Write_Data = 64'h11; tick();
        Write_Data = 64'hAA; rs1 = 7; rs2 = 7; dbg_addr = 7; #1;
        n_tests++;
        if (r1[0] !== 64'hAA || r2[0] !== 64'hAA) begin
            n_fail++; $display("FAIL bypass_on got %h/%h want aa", r1[0], r2[0]);
        end
        n_tests++;
        if (r1[1] !== 64'h11 || r2[1] !== 64'h11) begin
            n_fail++; $display("FAIL bypass_off got %h/%h want 11", r1[1], r2[1]);
        end
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (dg[c] !== 64'h11) begin
                n_fail++; $display("FAIL dbg_no_bypass dut%0d got %h want 11", c, dg[c]);
            end
        end
        tick(); RegWrite = 0; #1;
        n_tests++;
        if (r1[1] !== 64'hAA || r2[1] !== 64'hAA) begin
            n_fail++; $display("FAIL bypass_off_next got %h/%h want aa", r1[1], r2[1]);
        end
    endtask

    task automatic test_clear_sweep();
        int busy_cnt [3];
        int done_cnt [3];
        idle_inputs();
        preload();
        clear_req = 1; tick(); clear_req = 0;  // edge k
        for (int c = 0; c < 3; c++) begin busy_cnt[c] = 0; done_cnt[c] = 0; end
        for (int j = 0; j < 36; j++) begin
            rs1 = 5'(j % 32); rs2 = 5'((j + 31) % 32); dbg_addr = 5'((j + 7) % 32);
            RegWrite = (j == 3); rd = 31; Write_Data = 64'h55;
            clear_req = (j == 9);
            #1;
            for (int c = 0; c < 3; c++) begin
                if (bz[c] === 1'b1) busy_cnt[c]++;
                if (dn[c] === 1'b1) done_cnt[c]++;
                n_tests++;
                if (r1[c] !== exp_rd(c, rs1, 1) || r2[c] !== exp_rd(c, rs2, 1) ||
                    dg[c] !== exp_rd(c, dbg_addr, 0) || bz[c] !== m_busy[c] || dn[c] !== m_done[c]) begin
                    n_fail++;
                    $display("FAIL sweep dut%0d j=%0d got %h %h %h b%b d%b want %h %h %h b%b d%b", c, j,
                             r1[c], r2[c], dg[c], bz[c], dn[c], exp_rd(c, rs1, 1), exp_rd(c, rs2, 1),
                             exp_rd(c, dbg_addr, 0), m_busy[c], m_done[c]);
                end
            end
            if (j >= 1 && j <= 31) begin
                n_tests++;
                if (r1[0] !== 64'(j) || r2[0] !== 64'h0) begin
                    n_fail++;
                    $display("FAIL sweep_order j=%0d got %h/%h want %h/0", j, r1[0], r2[0], 64'(j));
                end
            end
            tick();
        end
        RegWrite = 0; clear_req = 0;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (busy_cnt[c] != NR[c] || done_cnt[c] != 1) begin
                n_fail++;
                $display("FAIL sweep_len dut%0d got busy=%0d done=%0d want %0d/1", c, busy_cnt[c], done_cnt[c], NR[c]);
            end
        end
        rs1 = 31; #1;
        n_tests++;
        if (r1[0] !== 64'h0) begin
            n_fail++; $display("FAIL write_during_sweep got %h want 0", r1[0]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        idle_inputs();
        preload();
        clear_req = 1; tick(); clear_req = 0;
        repeat (4) tick();
        reset = 1; tick(); reset = 0;  // edge k+5
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (bz[c] !== 1'b0) begin
                n_fail++; $display("FAIL reset_mid_busy dut%0d got %b want 0", c, bz[c]);
            end
        end
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a); #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (dg[c] !== 64'h0) begin
                    n_fail++; $display("FAIL reset_mid_clear dut%0d addr %0d got %h want 0", c, a, dg[c]);
                end
            end
        end
        repeat (3) begin
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (dn[c] !== 1'b0) begin
                    n_fail++; $display("FAIL reset_mid_done dut%0d got %b want 0", c, dn[c]);
                end
            end
            tick();
        end
    endtask

    task automatic test_write_and_clear();
        logic [63:0] d;
        idle_inputs();
        d = {$urandom, $urandom} | 64'h1;
        RegWrite = 1; rd = 9; Write_Data = d; clear_req = 1; tick();
        RegWrite = 0; clear_req = 0; rs1 = 9; #1;
        n_tests++;
        if (r1[0] !== d || bz[0] !== 1'b1) begin
            n_fail++; $display("FAIL write_with_req got %h b%b want %h b1", r1[0], bz[0], d);
        end
        repeat (34) tick();
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (r1[c] !== 64'h0 || bz[c] !== 1'b0) begin
                n_fail++; $display("FAIL write_with_req_after dut%0d got %h b%b want 0 b0", c, r1[c], bz[c]);
            end
        end
    endtask

    task automatic test_out_of_range();
        idle_inputs();
        RegWrite = 1; rd = 30; Write_Data = 64'hBAD; tick();
        RegWrite = 0; rs1 = 30; #1;
        n_tests++;
        if (r1[2] !== 64'h0) begin
            n_fail++; $display("FAIL oor_read got %h want 0", r1[2]);
        end
        n_tests++;
        if (r1[0] !== 64'hBAD) begin
            n_fail++; $display("FAIL in_range_30 got %h want bad", r1[0]);
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int n = 0; n < 500; n++) begin
            reset      = ($urandom_range(0, 149) == 0);
            clear_req  = ($urandom_range(0, 39) == 0);
            RegWrite   = $urandom_range(0, 1);
            rd         = 5'($urandom_range(0, 31));
            Write_Data = {$urandom, $urandom};
            rs1        = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2        = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            dbg_addr   = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            #1;
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (r1[c] !== exp_rd(c, rs1, 1) || r2[c] !== exp_rd(c, rs2, 1) ||
                    dg[c] !== exp_rd(c, dbg_addr, 0) || bz[c] !== m_busy[c] || dn[c] !== m_done[c]) begin
                    n_fail++;
                    $display("FAIL random dut%0d n=%0d got %h %h %h b%b d%b want %h %h %h b%b d%b", c, n,
                             r1[c], r2[c], dg[c], bz[c], dn[c], exp_rd(c, rs1, 1), exp_rd(c, rs2, 1),
                             exp_rd(c, dbg_addr, 0), m_busy[c], m_done[c]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_write_zero();
        test_bypass();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_write_and_clear();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
Parametrised general-purpose register file for the pipelined RISC-V core. It generalises the fixed 64-bit x 32 design in three ways: configurable width and depth, a hardwired-zero entry 0, and write-to-read bypass for the decode stage. It also adds a debug read port and a sequential clear engine, which sweeps one entry per cycle under a req/busy/done handshake. It sits between the decode stage (reads) and the writeback stage (writes).

Parameters:
XLEN, 64, data width of each entry in bits.
NREGS, 32, number of entries (2..64). The address width is AW = clog2(NREGS), a derived localparam and not user-set.
ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are dropped.
BYPASS, 1, when 1, a same-cycle write to a register being read is forwarded to the read port.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
rs1  in  AW  read address, port 1.
rs2  in  AW  read address, port 2.
rd  in  AW  write address.
RegWrite  in  1  write enable.
Write_Data  in  XLEN  write data.
Read_Data_1  out  XLEN  combinational read data, port 1.
Read_Data_2  out  XLEN  combinational read data, port 2.
dbg_addr  in  AW  debug read address.
dbg_data  out  XLEN  combinational debug read data; never bypassed.
clear_req  in  1  request a full sequential clear; sampled on the rising edge.
clear_busy  out  1  high while the clear sweep is in progress.
clear_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset (synchronous, active-high): on a rising edge with reset=1, all NREGS entries become 0, the FSM goes to IDLE, the sweep index goes to 0, and clear_busy=0, clear_done=0. Reset overrides RegWrite and clear_req. Reset mid-sweep aborts the sweep, and all entries are 0 after that edge.
- Write: at the rising edge, entry[rd] <= Write_Data when all of the following hold:
  - RegWrite=1,
  - clear_busy=0,
  - rd < NREGS,
  - not (ZERO_REG=1 and rd=0).
  Otherwise the write is dropped silently. The pipeline must stall writeback while clear_busy=1.
- Read: each read port and dbg_data is combinational from the addressed entry, with no latency. An address >= NREGS reads 0. With ZERO_REG=1, address 0 reads 0.
- Bypass: when BYPASS=1, Read_Data_N = Write_Data if all of the following hold:
  - RegWrite=1,
  - clear_busy=0,
  - rd = rsN,
  - rd < NREGS,
  - rd is not the zero register.
  Otherwise the stored value is returned. The dbg port is never bypassed. With BYPASS=0, a read in the write cycle returns the old value, and the new value is visible from the next cycle.
- Clear FSM, states IDLE -> CLEAR -> DONE -> IDLE:
  - IDLE: clear_req=1 at edge k moves to CLEAR, sets idx=0 and clear_busy=1 (visible after edge k).
  - CLEAR: at each edge, entry[idx] <= 0 and idx increments. Entries 0..NREGS-1 are cleared on edges k+1..k+NREGS. At the edge that clears idx=NREGS-1, the FSM moves to DONE.
  - DONE: clear_busy=0 and clear_done=1 for exactly one cycle, then IDLE at the next edge.
  - clear_req is ignored in CLEAR and DONE; it is not queued. A new request is accepted only in IDLE.
- During CLEAR, reads return current stored contents, so entries are partially cleared; bypass is disabled.
- The idx counter is AW+1 bits wide to avoid wrap at NREGS = 2^AW. Sweep duration is exactly NREGS cycles of busy.
- Simultaneous RegWrite and clear_req in IDLE: the write is performed at edge k (clear_busy is still 0), and the sweep then clears that entry as normal.

Test Plan:
- Reset then read: XLEN=64, NREGS=32. Assert reset for 1 cycle -> Read_Data_1/2 = 0 for rs = 0..31; clear_busy=0; clear_done=0.
- Write/read and zero register: write 0xDEADBEEF_CAFEF00D to rd=5, then read rs1=5 -> 0xDEADBEEF_CAFEF00D. Write 0x1234 to rd=0 -> rs2=0 reads 0; dbg_addr=0 reads 0.
- Bypass: in the same cycle, RegWrite=1, rd=7, Write_Data=0xAA, rs1=7, rs2=7, with old entry[7]=0x11 -> both ports read 0xAA before the edge. With BYPASS=0 the ports read 0x11, then 0xAA after the edge.
- Clear sweep: preload entries 1..31 with their index, pulse clear_req at edge k -> clear_busy high for cycles k+1..k+32, entry[i] reads 0 from the cycle after edge k+1+i, clear_done=1 only in the cycle after edge k+32. A clear_req pulse at k+10 is ignored (no extra busy cycles).
- Write during sweep and reset mid-sweep: RegWrite=1, rd=31, data=0x55 while clear_busy=1 -> entry[31]=0 after the sweep. A new sweep with reset=1 at k+5 -> clear_busy=0 next cycle, all entries 0, no clear_done pulse.
- Out-of-range addresses: NREGS=24. Write rd=30 -> no entry changes; rs1=30 reads 0. A sweep lasts 24 busy cycles.
